// File: rtl/connector_pkg.sv
// Shared types and default widths for the trace connector: the commit record
// format plus the default commit width and FIFO depth.
package connector_pkg;

  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int PRIV_W = 2;

  localparam int NRET                 = 2;
  localparam int CONNECTOR_FIFO_DEPTH = 8;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   iaddr;
    logic [ILEN-1:0]   insn;
    logic [PRIV_W-1:0] priv_lvl;
  } uop_entry_s;

endpackage

// File: rtl/connector_compact.sv
// Packs the live commit slots into a gap-free write vector, in slot order,
// limited by the space available this cycle. Purely combinational.
module connector_compact #(
  parameter int NRET = 2,
  parameter int FW   = 4
) (
  input  connector_pkg::uop_entry_s slots [NRET],
  input  logic [FW-1:0]             free,
  output connector_pkg::uop_entry_s wr_vec [NRET],
  output logic [FW-1:0]             n_wr,
  output logic [FW-1:0]             n_drop
);
  import connector_pkg::*;

  always_comb begin
    for (int j = 0; j < NRET; j++) wr_vec[j] = '0;
    n_wr   = '0;
    n_drop = '0;
    // Earlier slots claim space first, so a drop only ever hits later slots.
    for (int i = 0; i < NRET; i++) begin
      if (slots[i].valid) begin
        if (n_wr < free) begin
          for (int j = 0; j < NRET; j++) begin
            if (n_wr == FW'(j)) wr_vec[j] = slots[i];
          end
          n_wr = n_wr + FW'(1);
        end else begin
          n_drop = n_drop + FW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/connector_commit_fifo.sv
// In-order commit FIFO feeding the connector fsm: NRET records in, one out per
// cycle, drops flagged on overflow. CONNECTOR_DROP_CNT_EN builds the drop counter.
module connector_commit_fifo #(
  parameter int NRET  = connector_pkg::NRET,
  parameter int DEPTH = connector_pkg::CONNECTOR_FIFO_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  connector_pkg::uop_entry_s  uop_entry_i [NRET],
  output connector_pkg::uop_entry_s  uop_entry_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);
  import connector_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  uop_entry_s    mem [DEPTH];
  uop_entry_s    wr_vec [NRET];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] count;
  logic [FW-1:0] free;
  logic [FW-1:0] n_wr;
  logic [FW-1:0] n_drop;
  logic          pop;
  logic          overflow;

  // The fsm drains every cycle; a pop this cycle frees its slot for the write.
  assign pop  = (count != '0);
  assign free = FW'(DEPTH) - count + FW'(pop);

  connector_compact #(.NRET(NRET), .FW(FW)) u_compact (
    .slots  (uop_entry_i),
    .free   (free),
    .wr_vec (wr_vec),
    .n_wr   (n_wr),
    .n_drop (n_drop)
  );

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (FW'(i) < n_wr) mem[wr_ptr + AW'(i)] <= wr_vec[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + n_wr[AW-1:0];
      count  <= count + n_wr - FW'(pop);
      if (n_drop != '0) overflow <= 1'b1;
    end
  end

`ifdef CONNECTOR_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   drop_sum;

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt <= '0;
    end else if (drop_sum[CNT_W]) begin
      drop_cnt <= '1;
    end else begin
      drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

  assign uop_entry_o   = pop ? mem[rd_ptr] : '0;
  assign count_o       = count;
  assign full_o        = (count == FW'(DEPTH));
  assign almost_full_o = (count > FW'(DEPTH - NRET));
  assign overflow_o    = overflow;

endmodule
